// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with branch/jump target adder.
// Extension and target addition happen at accept time; results sit in a
// 2-entry FIFO with a valid/ready handshake toward the execute stage.
module imm_ext_pipe #(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned SHAMT  = 2,
  parameter int unsigned LUI_SH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  data_in,
  input  logic [2:0]       mode,
  input  logic [OUT_W-1:0] pc_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic [OUT_W-1:0] target_out,
  output logic             mode_err
);

  // Shifted immediates must fit the datapath without losing significant bits.
  if (OUT_W < IN_W + SHAMT) begin : gen_shamt_chk
    $error("imm_ext_pipe: OUT_W must be >= IN_W + SHAMT");
  end
  if (OUT_W < IN_W + LUI_SH) begin : gen_lui_chk
    $error("imm_ext_pipe: OUT_W must be >= IN_W + LUI_SH");
  end

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [OUT_W-1:0] target;
    logic             err;
  } entry_t;

  entry_t     mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;

  logic [OUT_W-1:0] zext, sext;
  entry_t           new_entry;
  logic             push, pop;

  assign zext = {{(OUT_W-IN_W){1'b0}}, data_in};
  assign sext = {{(OUT_W-IN_W){data_in[IN_W-1]}}, data_in};

  // Decode the mode into the extended immediate and its target address.
  always_comb begin
    new_entry = '0;
    case (mode)
      3'b000:  new_entry.data = zext;
      3'b001:  new_entry.data = sext;
      3'b010:  new_entry.data = sext << SHAMT;
      3'b011:  new_entry.data = zext << LUI_SH;
      3'b100:  new_entry.data = zext << SHAMT;
      default: new_entry.err  = 1'b1;
    endcase
    // Carry out of the adder is intentionally dropped.
    new_entry.target = pc_in + new_entry.data;
  end

  // Handshake uses registered count only, so in_ready never depends on out_ready.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign data_out   = mem_q[rd_ptr_q].data;
  assign target_out = mem_q[rd_ptr_q].target;
  assign mode_err   = mem_q[rd_ptr_q].err;

  // Occupancy next-state from push/pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; reset empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed cases plus randomized traffic
// checked against a queue-based reference model.
module tb_imm_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic [2:0]  mode;
  logic [31:0] pc_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic [31:0] target_out;
  logic        mode_err;

  imm_ext_pipe #(
    .IN_W  (16),
    .OUT_W (32),
    .SHAMT (2),
    .LUI_SH(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .mode      (mode),
    .pc_in     (pc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .target_out(target_out),
    .mode_err  (mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint unsigned d;
    longint unsigned t;
    bit              e;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference: arithmetic view of each mode on 32-bit words.
  function automatic exp_t model(input logic [15:0] d, input logic [2:0] m,
                                 input logic [31:0] pc);
    exp_t    r;
    longint  s;
    longint unsigned mask = 64'hFFFF_FFFF;
    s = (d >= 16'h8000) ? longint'(d) - 65536 : longint'(d);
    r.e = 1'b0;
    case (m)
      3'd0:    r.d = longint'(d);
      3'd1:    r.d = s & mask;
      3'd2:    r.d = (s * 4) & mask;
      3'd3:    r.d = (longint'(d) * 65536) & mask;
      3'd4:    r.d = longint'(d) * 4;
      default: begin r.d = 0; r.e = 1'b1; end
    endcase
    r.t = (longint'(pc) + r.d) & mask;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive, compare against model at negedge, advance model at posedge.
  task automatic cyc(input bit iv, input logic [15:0] d, input logic [2:0] m,
                     input logic [31:0] pc, input bit ordy);
    bit ps, pp;
    in_valid = iv; data_in = d; mode = m; pc_in = pc; out_ready = ordy;
    @(negedge clk);
    check("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("data_out", data_out, q[0].d[31:0]);
      check("target_out", target_out, q[0].t[31:0]);
      check("mode_err", {31'd0, mode_err}, {31'd0, q[0].e});
    end
    ps = iv && (q.size() < 2);
    pp = (q.size() != 0) && ordy;
    @(posedge clk);
    if (pp) void'(q.pop_front());
    if (ps) q.push_back(model(d, m, pc));
    #1;
  endtask

  // Literal check of the current head entry.
  task automatic lit(input string tag, input logic [31:0] d, input logic [31:0] t,
                     input bit e);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, data_out, d);
    check({tag, "_target"}, target_out, t);
    check({tag, "_err"}, {31'd0, mode_err}, {31'd0, e});
  endtask

  logic [31:0] held_d;

  initial begin
    rst_n = 1'b1; in_valid = 0; data_in = 0; mode = 0; pc_in = 0; out_ready = 0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_data", data_out, 32'd0);
    check("rst_target", target_out, 32'd0);
    check("rst_err", {31'd0, mode_err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed mode cases, streaming with out_ready high.
    cyc(1, 16'h8004, 3'b010, 32'h0040_0010, 1);
    lit("branch", 32'hFFFE_0010, 32'h003E_0020, 0);
    cyc(1, 16'h8004, 3'b000, 32'hFFFF_FFF0, 1);
    lit("zext", 32'h0000_8004, 32'h0000_7FF4, 0);
    cyc(1, 16'h8004, 3'b001, 32'hFFFF_FFF0, 1);
    lit("sext", 32'hFFFF_8004, 32'hFFFF_7FF4, 0);
    cyc(1, 16'h1234, 3'b011, 32'hFFFF_FFF0, 1);
    lit("lui", 32'h1234_0000, 32'h1233_FFF0, 0);
    cyc(1, 16'h1234, 3'b101, 32'h0000_0100, 1);
    lit("illegal", 32'h0, 32'h0000_0100, 1);
    cyc(0, 16'h0, 3'b000, 32'h0, 1);

    // Backpressure: A and B fill the buffer, C is held off.
    cyc(1, 16'h00AA, 3'b000, 32'h10, 0);
    held_d = data_out;
    cyc(1, 16'h00BB, 3'b000, 32'h20, 0);
    check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    cyc(1, 16'h00CC, 3'b000, 32'h30, 0);
    cyc(1, 16'h00CC, 3'b000, 32'h30, 0);
    check("bp_head_stable", data_out, held_d);
    cyc(1, 16'h00CC, 3'b000, 32'h30, 1);  // pops A, C still refused
    cyc(1, 16'h00CC, 3'b000, 32'h30, 1);  // pops B, accepts C
    cyc(0, 16'h0, 3'b000, 32'h0, 1);      // pops C
    cyc(0, 16'h0, 3'b000, 32'h0, 1);

    // Streaming: count never exceeds one.
    for (int i = 0; i < 20; i++)
      cyc(1, 16'($urandom), 3'($urandom_range(4)), $urandom, 1);
    cyc(0, 16'h0, 3'b000, 32'h0, 1);

    // Reset with a full buffer, mid-cycle.
    cyc(1, 16'h0111, 3'b000, 32'h0, 0);
    cyc(1, 16'h0222, 3'b000, 32'h0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", data_out, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    in_valid = 1; data_in = 16'h0333; mode = 3'b000; pc_in = 32'h1000; out_ready = 1;
    @(posedge clk);
    q.push_back(model(16'h0333, 3'b000, 32'h1000));
    #1;
    lit("post_rst", 32'h0000_0333, 32'h0000_1333, 0);
    cyc(0, 16'h0, 3'b000, 32'h0, 1);
    cyc(0, 16'h0, 3'b000, 32'h0, 1);

    // Randomized traffic, all modes including illegal ones.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), 16'($urandom), 3'($urandom), $urandom, 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
